// File: rtl/dual_slope_integrator.sv
`default_nettype none
// ============================================================================
// Module   : dual_slope_integrator
// Purpose  : Cycle-accurate digital stand-in for the dual-slope ADC front end
//            (input switch bank, saturating integrator, zero comparator).
// Revision : 1.0  - initial release
// ============================================================================
module dual_slope_integrator #(
   parameter int VM_W  = 10,
   parameter int REF   = 1000,
   parameter int ACC_W = 22,
   parameter int CNT_W = 16
) (
   input  logic                    ck,
   input  logic                    rst_s,
   input  logic [VM_W-1:0]         vm,
   input  logic                    ch_zr,
   input  logic                    ch_vm,
   input  logic                    ch_ref,
   output logic                    Vint_z,
   output logic signed [ACC_W-1:0] acc,
   output logic [1:0]              phase,
   output logic [CNT_W-1:0]        phase_cnt,
   output logic                    ovf,
   output logic                    sw_err
);

   typedef enum logic [1:0] {
      PH_IDLE  = 2'd0,
      PH_ZERO  = 2'd1,
      PH_INTEG = 2'd2,
      PH_DEINT = 2'd3
   } phase_t;

   localparam logic signed [ACC_W:0] c_acc_max = {2'b00, {(ACC_W-1){1'b1}}};
   localparam logic signed [ACC_W:0] c_acc_min = {2'b11, {(ACC_W-1){1'b0}}};
   localparam logic signed [ACC_W:0] c_ref_ext = (ACC_W+1)'(REF);

   phase_t                    r_state;
   logic signed [ACC_W-1:0]   r_acc;
   logic                      r_vint_z;
   logic [CNT_W-1:0]          r_cnt;
   logic                      r_ovf;
   logic                      r_sw_err;

   phase_t                    w_state_nxt;
   logic signed [ACC_W-1:0]   w_acc_nxt;
   logic                      w_vint_z_nxt;
   logic [CNT_W-1:0]          w_cnt_nxt;
   logic                      w_ovf_nxt;
   logic                      w_sw_err_nxt;

   logic                      w_multi;
   logic signed [ACC_W:0]     w_acc_ext;
   logic signed [ACC_W:0]     w_vm_ext;
   logic signed [ACC_W:0]     w_sum;
   logic signed [ACC_W-1:0]   w_sat;
   logic                      w_hit;
   logic                      w_sat_le0;
   logic [CNT_W-1:0]          w_cnt_inc;

   assign w_multi = (ch_zr & ch_vm) | (ch_zr & ch_ref) | (ch_vm & ch_ref);

   // One extra bit of headroom so the clamp sees the true sum before wrapping.
   assign w_acc_ext = {r_acc[ACC_W-1], r_acc};
   assign w_vm_ext  = {{(ACC_W+1-VM_W){1'b0}}, vm};
   assign w_sum     = ch_vm ? (w_acc_ext + w_vm_ext) : (w_acc_ext - c_ref_ext);

   always_comb begin
      w_sat = w_sum[ACC_W-1:0];
      w_hit = 1'b0;
      if (w_sum >= c_acc_max) begin
         w_sat = c_acc_max[ACC_W-1:0];
         w_hit = 1'b1;
      end else if (w_sum <= c_acc_min) begin
         w_sat = c_acc_min[ACC_W-1:0];
         w_hit = 1'b1;
      end
   end

   assign w_sat_le0 = w_sat[ACC_W-1] | (w_sat == '0);
   assign w_cnt_inc = (r_cnt == '1) ? r_cnt : (r_cnt + CNT_W'(1));

   always_comb begin
      w_state_nxt  = r_state;
      w_acc_nxt    = r_acc;
      w_vint_z_nxt = r_vint_z;
      w_cnt_nxt    = r_cnt;
      w_ovf_nxt    = r_ovf;
      w_sw_err_nxt = r_sw_err;
      if (w_multi) begin
         // Conflicting switches: flag it and freeze everything else.
         w_sw_err_nxt = 1'b1;
      end else begin
         if (ch_zr) begin
            w_state_nxt  = PH_ZERO;
            w_acc_nxt    = '0;
            w_ovf_nxt    = 1'b0;
            w_sw_err_nxt = 1'b0;
            w_vint_z_nxt = 1'b0;
         end else if (ch_vm) begin
            w_state_nxt  = PH_INTEG;
            w_acc_nxt    = w_sat;
            w_ovf_nxt    = r_ovf | w_hit;
            w_vint_z_nxt = 1'b0;
         end else if (ch_ref) begin
            w_state_nxt  = PH_DEINT;
            w_acc_nxt    = w_sat;
            w_ovf_nxt    = r_ovf | w_hit;
            w_vint_z_nxt = w_sat_le0;
         end else begin
            w_state_nxt  = PH_IDLE;
            w_vint_z_nxt = 1'b0;
         end
         w_cnt_nxt = (w_state_nxt != r_state) ? CNT_W'(1) : w_cnt_inc;
      end
   end

   always_ff @(posedge ck) begin
      if (rst_s) begin
         r_state  <= PH_IDLE;
         r_acc    <= '0;
         r_vint_z <= 1'b0;
         r_cnt    <= '0;
         r_ovf    <= 1'b0;
         r_sw_err <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_acc    <= w_acc_nxt;
         r_vint_z <= w_vint_z_nxt;
         r_cnt    <= w_cnt_nxt;
         r_ovf    <= w_ovf_nxt;
         r_sw_err <= w_sw_err_nxt;
      end
   end

   assign Vint_z    = r_vint_z;
   assign acc       = r_acc;
   assign phase     = r_state;
   assign phase_cnt = r_cnt;
   assign ovf       = r_ovf;
   assign sw_err    = r_sw_err;

endmodule
`default_nettype wire

// File: tb/tb_dual_slope_integrator.sv
`default_nettype none
// ============================================================================
// Module   : tb_dual_slope_integrator
// Purpose  : Self-checking bench: directed conversions plus random switching
//            against an arithmetic model of the integrator front end.
// Revision : 1.0  - initial release
// ============================================================================
module tb_dual_slope_integrator;

   localparam int      VM_W    = 10;
   localparam int      REF     = 1000;
   localparam int      ACC_W   = 22;
   localparam int      CNT_W   = 16;
   localparam longint  ACC_MAX = (longint'(1) <<< (ACC_W-1)) - 1;
   localparam longint  ACC_MIN = -(longint'(1) <<< (ACC_W-1));
   localparam longint  CNT_MAX = (longint'(1) <<< CNT_W) - 1;

   typedef struct packed {
      logic [63:0] acc;
      logic [1:0]  ph;
      logic [31:0] cnt;
      logic        vz;
      logic        ovf;
      logic        err;
   } mstate_t;

   logic                    ck = 1'b0;
   logic                    rst_s = 1'b1;
   logic [VM_W-1:0]         vm = '0;
   logic                    ch_zr = 1'b0;
   logic                    ch_vm = 1'b0;
   logic                    ch_ref = 1'b0;
   logic                    Vint_z;
   logic signed [ACC_W-1:0] acc;
   logic [1:0]              phase;
   logic [CNT_W-1:0]        phase_cnt;
   logic                    ovf;
   logic                    sw_err;

   int      n_checks = 0;
   int      n_fail   = 0;
   logic    chk_en   = 1'b0;
   mstate_t m        = '0;

   dual_slope_integrator #(
      .VM_W (VM_W),
      .REF  (REF),
      .ACC_W(ACC_W),
      .CNT_W(CNT_W)
   ) dut (
      .ck       (ck),
      .rst_s    (rst_s),
      .vm       (vm),
      .ch_zr    (ch_zr),
      .ch_vm    (ch_vm),
      .ch_ref   (ch_ref),
      .Vint_z   (Vint_z),
      .acc      (acc),
      .phase    (phase),
      .phase_cnt(phase_cnt),
      .ovf      (ovf),
      .sw_err   (sw_err)
   );

   always #5 ck = ~ck;

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference behaviour: phase from the single active switch, acc as a
   // clamped integer, sticky flags, and a run-length counter of the phase.
   function automatic mstate_t model_step(input mstate_t s, input logic r, input logic z,
                                          input logic v, input logic f,
                                          input logic [VM_W-1:0] x);
      mstate_t n;
      longint  a;
      int      nph;
      n = s;
      if (r) return '0;
      if (int'(z) + int'(v) + int'(f) > 1) begin
         n.err = 1'b1;
         return n;
      end
      nph = z ? 1 : v ? 2 : f ? 3 : 0;
      a   = $signed(s.acc);
      if (z) begin
         a     = 0;
         n.ovf = 1'b0;
         n.err = 1'b0;
      end else if (v || f) begin
         a = v ? a + longint'(x) : a - REF;
         if (a >= ACC_MAX) begin
            a     = ACC_MAX;
            n.ovf = 1'b1;
         end else if (a <= ACC_MIN) begin
            a     = ACC_MIN;
            n.ovf = 1'b1;
         end
      end
      n.acc = a;
      n.vz  = f && (a <= 0);
      if (nph != int'(s.ph)) n.cnt = 1;
      else if (longint'(s.cnt) >= CNT_MAX) n.cnt = 32'(CNT_MAX);
      else n.cnt = s.cnt + 1;
      n.ph = 2'(nph);
      return n;
   endfunction

   always @(posedge ck) m <= model_step(m, rst_s, ch_zr, ch_vm, ch_ref, vm);

   always @(negedge ck) begin
      if (chk_en) begin
         check("acc",       longint'(acc),       $signed(m.acc));
         check("Vint_z",    longint'(Vint_z),    longint'(m.vz));
         check("phase",     longint'(phase),     longint'(m.ph));
         check("phase_cnt", longint'(phase_cnt), longint'(m.cnt));
         check("ovf",       longint'(ovf),       longint'(m.ovf));
         check("sw_err",    longint'(sw_err),    longint'(m.err));
      end
   end

   task automatic cyc(input logic r, input logic z, input logic v, input logic f,
                      input int unsigned val);
      @(negedge ck);
      rst_s  = r;
      ch_zr  = z;
      ch_vm  = v;
      ch_ref = f;
      vm     = val[VM_W-1:0];
      @(posedge ck);
      #1;
   endtask

   task automatic integrate(input int unsigned val, input int n);
      cyc(0, 1, 0, 0, 0);
      for (int k = 0; k < n; k++) cyc(0, 0, 1, 0, val);
   endtask

   task automatic deint_until_rise(output int edge_n);
      edge_n = -1;
      for (int k = 1; k <= 3000; k++) begin
         cyc(0, 0, 0, 1, 0);
         if (Vint_z === 1'b1) begin
            edge_n = k;
            break;
         end
      end
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_acc"},   longint'(acc),       0);
      check({tag, "_vz"},    longint'(Vint_z),    0);
      check({tag, "_phase"}, longint'(phase),     0);
      check({tag, "_cnt"},   longint'(phase_cnt), 0);
      check({tag, "_ovf"},   longint'(ovf),       0);
      check({tag, "_err"},   longint'(sw_err),    0);
   endtask

   initial begin : stim
      int rise;
      int first_ovf;
      int total;

      // Reset with arbitrary switch activity
      cyc(1, 1'($urandom), 1'($urandom), 1'($urandom), $urandom);
      chk_en = 1'b1;
      cyc(1, 1'($urandom), 1'($urandom), 1'($urandom), $urandom);
      check_reset_vals("reset");

      // Nominal conversions
      integrate(500, 1000);
      check("s2_acc",       longint'(acc),       500000);
      check("s2_model_acc", $signed(m.acc),      500000);
      check("s2_cnt",       longint'(phase_cnt), 1000);
      deint_until_rise(rise);
      check("s2_rise_500", rise, 500);
      check("s2_acc_at_rise", longint'(acc), 0);
      cyc(0, 0, 0, 1, 0);
      check("s2_vz_held", longint'(Vint_z), 1);
      cyc(0, 0, 0, 0, 0);
      check("s2_vz_fall", longint'(Vint_z), 0);

      integrate(333, 1000);
      deint_until_rise(rise);
      check("s2_rise_333", rise, 333);
      cyc(0, 0, 0, 0, 0);

      integrate(0, 1000);
      deint_until_rise(rise);
      check("s2_rise_0", rise, 1);
      check("s2_acc_vm0", longint'(acc), -1000);

      // Non-divisible input, straight from DEINT back to ZERO
      integrate(7, 999);
      check("s3_acc", longint'(acc), 6993);
      deint_until_rise(rise);
      check("s3_rise", rise, 7);
      check("s3_acc_at_rise", longint'(acc), -7);

      // Positive saturation
      cyc(0, 1, 0, 0, 0);
      first_ovf = -1;
      for (int k = 1; k <= 2100; k++) begin
         cyc(0, 0, 1, 0, 1023);
         if (ovf === 1'b1 && first_ovf < 0) first_ovf = k;
      end
      check("s4_first_ovf", first_ovf, 2051);
      check("s4_acc", longint'(acc), 2097151);
      check("s4_model_acc", $signed(m.acc), 2097151);
      cyc(0, 1, 0, 0, 0);
      check("s4_ovf_clr", longint'(ovf), 0);
      check("s4_acc_clr", longint'(acc), 0);

      // Illegal switch combination during INTEG
      for (int k = 0; k < 10; k++) cyc(0, 0, 1, 0, 5);
      for (int k = 0; k < 3; k++) cyc(0, 0, 1, 1, 5);
      check("s5_err",   longint'(sw_err),    1);
      check("s5_acc",   longint'(acc),       50);
      check("s5_phase", longint'(phase),     2);
      check("s5_cnt",   longint'(phase_cnt), 10);
      cyc(0, 0, 1, 0, 5);
      check("s5_resume_acc", longint'(acc),    55);
      check("s5_err_sticky", longint'(sw_err), 1);

      // Reset in the middle of de-integration
      integrate(500, 1000);
      for (int k = 0; k < 199; k++) cyc(0, 0, 0, 1, 0);
      cyc(1, 0, 0, 1, 0);
      check_reset_vals("s6");
      cyc(1, 0, 0, 1, 0);
      check("s6_vz_low", longint'(Vint_z), 0);
      cyc(0, 0, 0, 0, 0);

      // Random switching; long DEINT runs reach negative saturation
      total = 0;
      while (total < 20000) begin
         int sel;
         int len;
         sel = int'($urandom_range(0, 99));
         len = int'($urandom_range(1, 300));
         if (sel < 2) begin
            cyc(1, 1'($urandom), 1'($urandom), 1'($urandom), $urandom);
            len = 1;
         end else if (sel < 7) begin
            logic [2:0] pat;
            case ($urandom_range(0, 3))
               0:       pat = 3'b011;
               1:       pat = 3'b101;
               2:       pat = 3'b110;
               default: pat = 3'b111;
            endcase
            len = int'($urandom_range(1, 4));
            for (int k = 0; k < len; k++) cyc(0, pat[2], pat[1], pat[0], $urandom);
         end else if (sel < 15) begin
            len = int'($urandom_range(1, 3));
            for (int k = 0; k < len; k++) cyc(0, 1, 0, 0, $urandom);
         end else if (sel < 45) begin
            for (int k = 0; k < len; k++) cyc(0, 0, 1, 0, $urandom);
         end else if (sel < 85) begin
            if (sel > 80) len = int'($urandom_range(2000, 2600));
            for (int k = 0; k < len; k++) cyc(0, 0, 0, 1, 0);
         end else begin
            len = int'($urandom_range(1, 20));
            for (int k = 0; k < len; k++) cyc(0, 0, 0, 0, $urandom);
         end
         total += len;
      end

      cyc(0, 0, 0, 0, 0);
      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/dual_slope_integrator.md
# dual_slope_integrator

Cycle-accurate, synthesizable digital model of the dual-slope ADC analog front end: the input switch bank, the integrator and the zero-crossing comparator. It sits on the other side of the converter controller. It consumes the controller's switch commands `ch_zr`, `ch_vm` and `ch_ref`, and produces the comparator output `Vint_z` that ends the de-integration phase. Simulation and FPGA builds use it in place of the analog board, so the controller and the BCD counter can be exercised closed-loop with a known input code.

## Interface
Parameters:
- `VM_W`, default 10: width of the unsigned input-voltage code `vm`.
- `REF`, default 1000: reference magnitude subtracted per de-integration cycle. With a 1000-cycle integration phase, the final count equals `vm`.
- `ACC_W`, default 22: signed integrator width.
- `CNT_W`, default 16: width of the phase-duration counter.

Ports:
- `ck`: input, 1 bit. Single clock; all state changes on its rising edge.
- `rst_s`: input, 1 bit. Reset, synchronous and active-high.
- `vm`: input, VM_W bits. Unsigned input code. Sampled every cycle during integration.
- `ch_zr`: input, 1 bit. Auto-zero switch command.
- `ch_vm`: input, 1 bit. Input-voltage switch command (integrate).
- `ch_ref`: input, 1 bit. Reference switch command (de-integrate).
- `Vint_z`: output, 1 bit. Comparator output; high when the integrator has reached or crossed zero during de-integration.
- `acc`: output, ACC_W bits, signed. Integrator value.
- `phase`: output, 2 bits. Current phase: 0 IDLE, 1 ZERO, 2 INTEG, 3 DEINT.
- `phase_cnt`: output, CNT_W bits. Number of consecutive cycles spent in the current phase.
- `ovf`: output, 1 bit. Sticky saturation flag.
- `sw_err`: output, 1 bit. Sticky flag for an illegal switch combination.

## Operation
All outputs are registered. The switch inputs are decoded on every edge, in priority order:
- **`rst_s` = 1:** `acc`=0, `Vint_z`=0, `phase`=IDLE, `phase_cnt`=0, `ovf`=0, `sw_err`=0. This takes priority over everything and applies mid-phase.
- **More than one `ch_*` high:** `sw_err`←1. `acc`, `phase`, `phase_cnt` and `Vint_z` hold.
- **`ch_zr` only:** `acc`←0, `ovf`←0, `sw_err`←0, `Vint_z`←0, `phase`←ZERO. This is the only non-reset way to clear the sticky flags.
- **`ch_vm` only:** `acc`←sat(`acc` + zero-extended `vm`), `phase`←INTEG, `Vint_z`←0.
- **`ch_ref` only:** `acc`←sat(`acc` − REF), `phase`←DEINT, `Vint_z`←(new `acc` ≤ 0).
- **No `ch_*` high:** `acc` holds, `phase`←IDLE, `Vint_z`←0.

Arithmetic and width rules:
- Saturation limits are +(2^(ACC_W−1)−1) and −2^(ACC_W−1). Hitting either limit sets `ovf`.
- The sum is formed at ACC_W+1 bits before clamping.

Phase-duration counter:
- `phase_cnt` resets to 1 on any phase change. Otherwise it increments.
- It saturates at all-ones.
- It holds while `sw_err` is being asserted.

## Timing
- Latency: one cycle from a switch input to the `acc`, `phase` and `Vint_z` update. There is no combinational path from inputs to outputs.
- For `acc` = A > 0 at the start of DEINT, `Vint_z` rises on the ceil(A/REF)-th `ch_ref` edge. This is the same edge on which `acc` becomes ≤ 0.
- For A ≤ 0, `Vint_z` rises on the first `ch_ref` edge.
- `Vint_z` stays high for as long as `ch_ref` alone stays high. It falls on the first edge where `ch_ref` is low.
- `acc` keeps decrementing after the crossing and saturates negative if `ch_ref` is held long enough.
- Switching directly from INTEG to DEINT, with no idle cycle in between, is legal.
- Switching directly from DEINT back to ZERO is legal.

## Test plan
1. **Reset:** assert `rst_s` for 2 cycles with random `ch_*` inputs → `acc`=0, `Vint_z`=0, `phase`=0, `phase_cnt`=0, `ovf`=0, `sw_err`=0.
2. **Nominal conversion:** `ch_zr` for 1 cycle, then `ch_vm` for 1000 cycles with `vm`=500 → `acc`=500000, `phase_cnt`=1000. Then `ch_ref` → `Vint_z` rises on the 500th `ch_ref` edge with `acc`=0. Repeat with `vm`=333 → rise on edge 333. Repeat with `vm`=0 → rise on edge 1, `acc`=−1000.
3. **Non-divisible input:** `ch_vm` for 999 cycles with `vm`=7 → `acc`=6993. Then `ch_ref` → `Vint_z` rises on edge 7, `acc`=−7.
4. **Saturation:** `vm`=1023 for 2100 cycles → `acc`=2097151 and `ovf`=1 from cycle 2051 onward. Then `ch_zr` for 1 cycle → `ovf`=0, `acc`=0.
5. **Illegal switches:** `ch_vm` and `ch_ref` high together for 3 cycles during INTEG → `sw_err`=1; `acc`, `phase` and `phase_cnt` frozen. Subsequent `ch_vm` alone resumes integration with `sw_err` still 1.
6. **Reset mid-operation:** `rst_s` on DEINT edge 200 of scenario 2 → next edge has all outputs at reset values. `Vint_z` stays 0 even if `ch_ref` remains high with `rst_s` high.
